// File: rtl/trace_buffer_reader.sv
// rtl/trace_buffer_reader.sv - dumps the circular trace buffer oldest-first as a lane-serialised word stream
module trace_buffer_reader #(
   parameter int N            = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int TB_SIZE      = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [$clog2(TB_SIZE)-1:0]   tb_ptr,
   output logic [$clog2(TB_SIZE)-1:0]   tb_read_address,
   input  logic [DATA_WIDTH-1:0]        vector_in [N],
   input  logic                         compression_flag_in,
   output logic                         dumping,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_flag,
   output logic                         out_first,
   output logic                         out_last,
   output logic                         done
);

   localparam int AW = $clog2(TB_SIZE);
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(READ_LATENCY + 1);

   localparam logic [AW-1:0] ENTRY_MAX = AW'(TB_SIZE - 1);
   localparam logic [LW-1:0] LANE_MAX  = LW'(N - 1);
   localparam logic [CW-1:0] CNT_INIT  = CW'(READ_LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [AW-1:0]           entry_q, entry_d;
   logic [LW-1:0]           lane_q, lane_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    flag_q, flag_d;
   logic [DATA_WIDTH-1:0]   hold_q [N];
   logic [DATA_WIDTH-1:0]   hold_d [N];
   logic [AW-1:0]           oldest;
   logic [AW-1:0]           addr_next;

   // Depth need not be a power of two, so every increment wraps explicitly.
   assign oldest    = (tb_ptr == ENTRY_MAX) ? '0 : tb_ptr + AW'(1);
   assign addr_next = (addr_q == ENTRY_MAX) ? '0 : addr_q + AW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         entry_q <= '0;
         lane_q  <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         for (int i = 0; i < N; i++) hold_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         entry_q <= entry_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      entry_d = entry_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = oldest;
               entry_d = '0;
               lane_d  = '0;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         // Address was registered on entry, so READ_LATENCY+1 cycles here line up with valid read data.
         WAIT: begin
            if (cnt_q == '0) begin
               hold_d  = vector_in;
               flag_d  = compression_flag_in;
               lane_d  = '0;
               state_d = SEND;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SEND: begin
            if (out_ready) begin
               if (lane_q != LANE_MAX) begin
                  lane_d = lane_q + LW'(1);
               end else if (entry_q != ENTRY_MAX) begin
                  entry_d = entry_q + AW'(1);
                  addr_d  = addr_next;
                  cnt_d   = CNT_INIT;
                  state_d = WAIT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tb_read_address = addr_q;
   assign dumping         = (state_q == WAIT) || (state_q == SEND);
   assign out_valid       = (state_q == SEND);
   assign done            = (state_q == DONE);
   assign out_data        = out_valid ? hold_q[lane_q] : '0;
   assign out_flag        = out_valid & flag_q;
   assign out_first       = out_valid && (lane_q == '0);
   assign out_last        = out_valid && (lane_q == LANE_MAX) && (entry_q == ENTRY_MAX);

endmodule
